// File: rtl/scv_fracgen.sv
// Multi-channel fractional clock-enable generator: CE at CLK*MUL/DIV plus a phase counter per channel.
// Define SCV_FRACGEN_CECOUNT_EN to add the per-channel 16-bit CE pulse counter output CE_CNT.
module scv_fracgen #(
  parameter int NCH   = 3,
  parameter int ACC_W = 9,
  parameter int PH_W  = 2,
  parameter logic [NCH*ACC_W-1:0] MUL_INIT = {9'd22, 9'd1, 9'd88},
  parameter logic [NCH*ACC_W-1:0] DIV_INIT = {9'd105, 9'd7, 9'd315}
) (
  input  logic                       CLK,
  input  logic                       RES,
  input  logic [NCH-1:0]             EN,
  input  logic                       LOAD,
  input  logic [NCH*ACC_W-1:0]       MUL,
  input  logic [NCH*ACC_W-1:0]       DIV,
  output logic [NCH-1:0]             CE,
  output logic [NCH*PH_W-1:0]        PHASE,
  output logic [NCH*(2**PH_W)-1:0]   PH_STB
`ifdef SCV_FRACGEN_CECOUNT_EN
  ,
  output logic [NCH*16-1:0]          CE_CNT
`endif
);

  localparam int NPH = 2**PH_W;

  logic [NCH-1:0] ce;

  assign CE = ce;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [ACC_W-1:0] mul_q, mul_d;
    logic [ACC_W-1:0] div_q, div_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] rem;
    logic             degen, sat, hit;

    // One extra bit so acc + mul never wraps before the compare.
    assign sum   = {1'b0, acc_q} + {1'b0, mul_q};
    assign hit   = sum >= {1'b0, div_q};
    assign rem   = sum[ACC_W-1:0] - div_q;
    assign degen = (mul_q == '0) || (div_q == '0);
    assign sat   = !degen && (mul_q >= div_q);

    assign ce[ch] = EN[ch] & hit & ~degen & ~RES;

    always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
      mul_d = mul_q;
      div_d = div_q;
      acc_d = acc_q;
      ph_d  = ph_q;
      if (LOAD) begin
        mul_d = MUL[ch*ACC_W +: ACC_W];
        div_d = DIV[ch*ACC_W +: ACC_W];
        acc_d = '0;
        ph_d  = '0;
      end else if (EN[ch] && !degen) begin
        acc_d = sat ? '0 : (hit ? rem : sum[ACC_W-1:0]);
        ph_d  = ph_q + PH_W'(ce[ch]);
      end
    end

    always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
        // NOTE: the ratio registers are a tiny register file, so they are reset to their INIT values like any flop.
        mul_q <= MUL_INIT[ch*ACC_W +: ACC_W];
        div_q <= DIV_INIT[ch*ACC_W +: ACC_W];
        acc_q <= '0;
        ph_q  <= '0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        mul_q <= mul_d;
        div_q <= div_d;
        acc_q <= acc_d;
        ph_q  <= ph_d;
      end
    end

    assign PHASE[ch*PH_W +: PH_W] = ph_q;

    for (genvar p = 0; p < NPH; p++) begin : g_ph
      assign PH_STB[ch*NPH + p] = ce[ch] & (ph_q == PH_W'(p));
    end

`ifdef SCV_FRACGEN_CECOUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (LOAD)        cnt_d = '0;
      else if (ce[ch]) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RES) begin
      if (RES) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign CE_CNT[ch*16 +: 16] = cnt_q;
`endif
  end

endmodule
